// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch initiator. Drives the request side of an instruction
// memory whose read data is registered (one cycle latency, held while
// stalled), captures the returning (pc, instruction) pairs in a small FIFO
// and presents the FIFO head to decode through a valid/ready handshake.
// A redirect flushes everything in flight and restarts fetch at the target.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   imem_pc            sequential fetch address
//   imem_irreg_pc      redirect address (0 = none, memory uses imem_pc)
//   imem_stall         1 = memory holds its output, no new read
//   imem_instruction   registered read data from memory
//   redirect_valid     flush and restart fetch at redirect_pc
//   redirect_pc        restart target (low two bits ignored)
//   out_valid          FIFO head valid
//   out_pc             address of head instruction
//   out_instruction    head instruction
//   out_ready          decode accepts the head this cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_pc,
  output logic [ADDR_WIDTH-1:0] imem_irreg_pc,
  output logic                  imem_stall,
  input  logic [INST_WIDTH-1:0] imem_instruction,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_instruction,
  input  logic                  out_ready
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  // One extra bit so count can hold QUEUE_DEPTH, another so count plus the
  // in-flight read can never overflow the comparison.
  localparam int CNT_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  resp_valid_q;
  logic [ADDR_WIDTH-1:0] resp_pc_q;

  logic [ADDR_WIDTH-1:0] fifo_pc   [QUEUE_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [CNT_W-1:0]      occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [1:0]            unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Issue decision. Occupancy counts queued entries plus the read whose data
  // arrives next cycle; a same-cycle pop is deliberately not credited so the
  // check never depends on out_ready. A redirect always issues because it
  // empties the queue in the same cycle. During reset the memory is left
  // unstalled; whatever it reads is dropped since resp_valid_q is cleared.
  always_comb begin
    target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    occupancy  = count + CNT_W'(resp_valid_q);
    issue      = rst | redirect_valid | (occupancy < DEPTH_C);
    issue_addr = redirect_valid ? target : pc_q;
  end

  // Request side. The redirect target goes out on both address buses so a
  // target of zero still reaches memory through the sequential path.
  assign imem_pc       = rst ? RESET_PC : issue_addr;
  assign imem_irreg_pc = (redirect_valid & ~rst) ? target : '0;
  assign imem_stall    = ~issue;

  // Handshake and FIFO movement. A redirect discards the arriving response
  // and suppresses any pop, since the queue is being flushed anyway.
  assign out_valid       = (count != '0) & ~rst;
  assign push            = resp_valid_q & ~redirect_valid & ~rst;
  assign pop             = out_valid & out_ready & ~redirect_valid;
  assign out_pc          = fifo_pc[rd_ptr];
  assign out_instruction = fifo_inst[rd_ptr];

  // Fetch control and queue bookkeeping. pc_q always holds the next
  // sequential address; resp_valid_q marks that the memory output register
  // will hold fresh data for resp_pc_q next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      if (issue) begin
        resp_valid_q <= 1'b1;
        resp_pc_q    <= issue_addr;
        pc_q         <= issue_addr + ADDR_WIDTH'(4);
      end else begin
        resp_valid_q <= 1'b0;
      end

      if (redirect_valid) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage. No reset needed: entries are only read when count says
  // they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc_q;
      fifo_inst[wr_ptr] <= imem_instruction;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch initiator that drives the instruction memory's request side: pc, irregPc and stall. It consumes the 1-cycle-latency registered instruction read and buffers returned (pc, instruction) pairs in a small FIFO. The FIFO feeds decode through a valid/ready handshake. Branch/exception redirects flush in-flight and queued instructions and restart fetch at the target.

Parameters:
ADDR_WIDTH, 32, PC/address width
INST_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
QUEUE_DEPTH, 4, fetch queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high (asserted == RESET)
imem_pc  out  ADDR_WIDTH  sequential fetch address to memory
imem_irreg_pc  out  ADDR_WIDTH  redirect address; 0 = none (memory uses imem_pc)
imem_stall  out  1  1 = memory holds its output register, no new read
imem_instruction  in  INST_WIDTH  registered read data; valid one cycle after an unstalled request
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_WIDTH  restart target; bits [1:0] treated as 0
out_valid  out  1  queue head valid
out_pc  out  ADDR_WIDTH  address of head instruction
out_instruction  out  INST_WIDTH  head instruction
out_ready  in  1  decode accepts head

Behaviour:
- Memory contract: read address = imem_irreg_pc if nonzero, else imem_pc; data appears the next cycle; output is held while imem_stall=1.
- State: pc_q (next sequential address), resp_valid_q, resp_pc_q (address of the in-flight read), FIFO (pc, inst) with rd/wr pointers and count.
- Issue condition: issue = redirect_valid | ((count + resp_valid_q) < QUEUE_DEPTH). imem_stall = ~issue.
  - The check is conservative: a same-cycle pop is ignored.
  - Sustained full rate is still achieved with out_ready=1.
- Addresses driven, no redirect: imem_pc = pc_q, imem_irreg_pc = 0.
- Addresses driven, redirect: imem_pc = imem_irreg_pc = {redirect_pc[ADDR_WIDTH-1:2],2'b00}. This handles target 0 correctly via the pc path.
- On issue: resp_valid_q <= 1, resp_pc_q <= issued address, pc_q <= issued address + 4, modulo 2^ADDR_WIDTH (wraps FFFF_FFFC -> 0000_0000).
- No issue: resp_valid_q <= 0; pc_q unchanged. A held memory output is never re-accepted.
- Push: when resp_valid_q & ~redirect_valid, push (resp_pc_q, imem_instruction). Pushes never overflow, guaranteed by the issue condition.
- Pop: out_valid = (count != 0). Pop when out_valid & out_ready.
- Push and pop in the same cycle: count unchanged.
- Head outputs: out_pc/out_instruction = FIFO head; these are registered storage, not a bypass.
- Latency: issue at cycle t -> data at memory output t+1 -> out_valid at t+2.
- Redirect cycle:
  - FIFO cleared (count <= 0, pointers reset).
  - Arriving response discarded.
  - Pop ignored; out_valid is 0 next cycle.
  - Target request issued that same cycle; first target instruction has out_valid at redirect cycle + 2.
- Held head: out_pc/out_instruction stable while out_valid & ~out_ready.
- Reset (any time, including mid-stream or mid-redirect): pc_q <= RESET_PC, resp_valid_q <= 0, count <= 0, pointers <= 0.
  - Outputs during reset: out_valid=0, imem_pc=RESET_PC, imem_irreg_pc=0, imem_stall=0. Any read during reset is ignored because resp_valid_q=0.
  - First real issue is the first cycle with rst=0, at RESET_PC.
- Redirect during reset: ignored.

Test Plan:
- Streaming: memory word n = 0x1000_0000+n, out_ready=1 after reset.
  - out_valid rises cycle 2 after reset release.
  - Then (pc,inst) = (0,0x10000000),(4,0x10000001),(8,0x10000002)... one per cycle, no gaps, imem_stall never 1.
- Backpressure: out_ready=0 from reset.
  - count reaches 4; imem_stall=1 exactly when count+resp_valid_q=4.
  - Head holds (0,0x10000000).
  - Release out_ready: 4 queued entries drain in order, then stream resumes at pc 0x10 with no duplicate or skipped pc.
- Redirect mid-stream: redirect_valid one cycle with redirect_pc=0x200 while 3 entries queued.
  - Next cycle out_valid=0; imem_irreg_pc=0x200 during the redirect cycle.
  - Next outputs are pc 0x200,0x204,...; no pre-redirect pc appears afterwards.
- Redirect while full and stalled, target 0x0 with redirect_pc=0x3 (low bits ignored):
  - imem_stall=0, imem_pc=0, imem_irreg_pc=0 that cycle.
  - Stream restarts at pc 0.
- Wrap: redirect_pc=0xFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-operation: assert rst for 1 cycle with a full queue and redirect_valid=1.
  - Next cycle out_valid=0, count=0.
  - First output after release is (RESET_PC, mem[0]) at release+2.
